sad_search_scheduler: RTL and testbench

//  Sequences the full-search SAD motion-estimation datapath. Walks every candidate

---
 rtl/sad_search_scheduler_if.sv | 30 +++
 rtl/sad_search_scheduler.sv | 170 +++++++++++++++++
 tb/tb_sad_search_scheduler.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sad_search_scheduler_if.sv
// Request/response link between the SAD search scheduler and the SAD unit.
// Carries one request (index) and one SAD result per candidate position.
// req_valid/req_ready handshake on requests; rsp_valid is a one-cycle pulse.
interface sad_search_scheduler_if #(
    parameter int SAD_W = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_index;
    logic             rsp_valid;
    logic [SAD_W-1:0] rsp_sad;

    // Scheduler side: issues requests, consumes results
    modport master (
        output req_valid,
        output req_index,
        input  req_ready,
        input  rsp_valid,
        input  rsp_sad
    );

    // SAD unit side: accepts requests, returns results
    modport slave (
        input  req_valid,
        input  req_index,
        output req_ready,
        output rsp_valid,
        output rsp_sad
    );
endinterface

// File: rtl/sad_search_scheduler.sv
// Full-search SAD scheduler: walks every block position row-major, one request at a time, tracks min SAD.
// Latency: 3 cycles per position with zero-wait handshake; 3*P*P+1 cycles from start to done.
// Backpressure: req_valid/req_index hold until req_ready; waits indefinitely for rsp_valid.
// Optional feature macro SAD_EARLY_EXIT_EN: a zero SAD ends the search at that position.
module sad_search_scheduler #(
    parameter int FRAME_W = 64,
    parameter int BLK     = 16,
    parameter int SAD_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    sad_search_scheduler_if.master sad,
    output logic [SAD_W-1:0]       best_sad,
    output logic [31:0]            best_index,
    output logic [31:0]            best_x,
    output logic [31:0]            best_y
);

    localparam int          LOG2W = $clog2(FRAME_W);
    localparam int          P     = FRAME_W - BLK + 1;
    localparam logic [31:0] LAST  = 32'(P - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      x_q;
    logic [31:0]      y_q;
    logic [SAD_W-1:0] sad_q;
    logic             done_q;
    logic [31:0]      cur_index;
    logic             last_pos;
    logic             better;
    logic             early_exit;
    logic             launch;

    // Linear index of the current position; FRAME_W is a power of two so x*FRAME_W is a shift
    assign cur_index = (x_q << LOG2W) + y_q;
    assign last_pos  = (x_q == LAST) && (y_q == LAST);
    assign better    = (sad_q < best_sad);
    assign launch    = ((state == S_IDLE) || (state == S_DONE)) && start;

`ifdef SAD_EARLY_EXIT_EN
    assign early_exit = (sad_q == '0);
`else
    assign early_exit = 1'b0;
`endif

    assign sad.req_valid = (state == S_ISSUE);
    assign sad.req_index = cur_index;
    assign busy          = (state == S_ISSUE) || (state == S_WAIT) || (state == S_UPDATE);
    assign done          = done_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one outstanding request; results outside WAIT are ignored
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (sad.req_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sad.rsp_valid) begin
                    state_nxt = S_UPDATE;
                end
            end
            S_UPDATE: begin
                if (last_pos || early_exit) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_ISSUE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Position counters: cleared on launch, row-major advance after each update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else if (launch) begin
            x_q <= '0;
            y_q <= '0;
        end else if ((state == S_UPDATE) && !last_pos && !early_exit) begin
            if (y_q == LAST) begin
                y_q <= '0;
                x_q <= x_q + 32'd1;
            end else begin
                y_q <= y_q + 32'd1;
            end
        end
    end

    // Capture the SAD of the outstanding request so UPDATE compares a stable value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sad_q <= '0;
        end else if ((state == S_WAIT) && sad.rsp_valid) begin
            sad_q <= sad.rsp_sad;
        end
    end

    // Running minimum; strict less-than keeps the earliest position on ties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_sad   <= '1;
            best_index <= '0;
            best_x     <= '0;
            best_y     <= '0;
        end else if (launch) begin
            best_sad <= '1;
        end else if ((state == S_UPDATE) && better) begin
            best_sad   <= sad_q;
            best_index <= cur_index;
            best_x     <= x_q;
            best_y     <= cur_index - (x_q << LOG2W);
        end
    end

    // Done is a single pulse on entry to DONE, never on later DONE cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state == S_UPDATE) && (state_nxt == S_DONE);
        end
    end

    // A stalled request must not change while waiting for acceptance
    property p_req_stable;
        @(posedge clk) disable iff (!rst_n)
            (sad.req_valid && !sad.req_ready) |=> (sad.req_valid && $stable(sad.req_index));
    endproperty
    a_req_stable: assert property (p_req_stable);

    // Done marks the end of the search, so busy is already low
    property p_done_not_busy;
        @(posedge clk) disable iff (!rst_n) done |-> !busy;
    endproperty
    a_done_not_busy: assert property (p_done_not_busy);

endmodule

// File: tb/tb_sad_search_scheduler.sv
// Scoreboard bench for sad_search_scheduler: expected request indices and results are
// queued at stimulus time; a monitor pops and compares on each accepted request and done.
// A second instance with BLK == FRAME_W covers the single-position search.
`timescale 1ns/1ps
module tb_sad_search_scheduler;
    localparam int FRAME_W = 64;
    localparam int BLK     = 16;
    localparam int SAD_W   = 32;
    localparam int P       = FRAME_W - BLK + 1;

    typedef struct {
        logic [31:0] sad;
        logic [31:0] idx;
        logic [31:0] x;
        logic [31:0] y;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy;
    logic done;
    logic [31:0] best_sad;
    logic [31:0] best_index;
    logic [31:0] best_x;
    logic [31:0] best_y;

    logic s_start;
    logic s_busy;
    logic s_done;
    logic [31:0] s_best_sad;
    logic [31:0] s_best_index;
    logic [31:0] s_best_x;
    logic [31:0] s_best_y;

    always #5 clk = ~clk;

    sad_search_scheduler_if #(.SAD_W(SAD_W)) bus ();
    sad_search_scheduler_if #(.SAD_W(SAD_W)) sbus ();

    sad_search_scheduler #(.FRAME_W(FRAME_W), .BLK(BLK), .SAD_W(SAD_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .sad(bus),
        .best_sad(best_sad), .best_index(best_index), .best_x(best_x), .best_y(best_y)
    );

    sad_search_scheduler #(.FRAME_W(8), .BLK(8), .SAD_W(SAD_W)) dut_p1 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done), .sad(sbus),
        .best_sad(s_best_sad), .best_index(s_best_index), .best_x(s_best_x), .best_y(s_best_y)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_idx_q[$];
    res_t        res_q[$];

    int          mode       = 0;
    bit          rand_ready = 1'b0;
    bit          inject_en  = 1'b0;
    int          acc_cnt    = 0;
    bit          pend       = 1'b0;
    logic [31:0] pend_idx   = '0;
    bit          stall_prev = 1'b0;
    logic [31:0] stall_idx  = '0;

    bit          s_pend     = 1'b0;
    int          s_acc      = 0;
    logic [31:0] s_last_idx = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %0d expected none", name, act);
    endtask

    // SAD models: 0 = |index-1000|, 1 = constant 5, 2 = zero only at index 130
    function automatic logic [31:0] sad_model(input int m, input logic [31:0] idx);
        if (m == 1) return 32'd5;
        if (m == 2) return (idx == 32'd130) ? 32'd0 : 32'd9;
        return (idx > 32'd1000) ? (idx - 32'd1000) : (32'd1000 - idx);
    endfunction

    // SAD unit model: result the cycle after acceptance, optional random ready and stray results
    always @(negedge clk) begin
        if (!rst_n) begin
            pend          = 1'b0;
            stall_prev    = 1'b0;
            bus.rsp_valid = 1'b0;
            bus.rsp_sad   = '0;
            bus.req_ready = 1'b0;
        end else begin
            if (pend) begin
                bus.rsp_valid = 1'b1;
                bus.rsp_sad   = sad_model(mode, pend_idx);
                pend          = 1'b0;
            end else if (inject_en && bus.req_valid) begin
                bus.rsp_valid = 1'b1;
                bus.rsp_sad   = '0;
            end else begin
                bus.rsp_valid = 1'b0;
            end
            bus.req_ready = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
            if (stall_prev) begin
                check("stall_valid", 32'(bus.req_valid), 32'd1);
                check("stall_index", bus.req_index, stall_idx);
            end
            if (bus.req_valid && bus.req_ready) begin
                pend     = 1'b1;
                pend_idx = bus.req_index;
                acc_cnt++;
            end
            stall_prev = bus.req_valid && !bus.req_ready;
            stall_idx  = bus.req_index;
        end
    end

    // Monitor: compares accepted requests and done results against the scoreboard
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (bus.req_valid && bus.req_ready) begin
                if (exp_idx_q.size() == 0) fail("extra_request", bus.req_index);
                else check("req_index", bus.req_index, exp_idx_q.pop_front());
            end
            if (done) begin
                if (res_q.size() == 0) begin
                    fail("unexpected_done", best_index);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    check("best_sad", best_sad, r.sad);
                    check("best_index", best_index, r.idx);
                    check("best_x", best_x, r.x);
                    check("best_y", best_y, r.y);
                    check("busy_at_done", 32'(busy), 32'd0);
                end
            end
        end
    end

    // Single-position SAD unit: always ready, constant SAD 7
    always @(negedge clk) begin
        if (!rst_n) begin
            s_pend         = 1'b0;
            sbus.rsp_valid = 1'b0;
            sbus.rsp_sad   = '0;
            sbus.req_ready = 1'b1;
        end else begin
            sbus.rsp_valid = s_pend;
            sbus.rsp_sad   = 32'd7;
            s_pend         = 1'b0;
            sbus.req_ready = 1'b1;
            if (sbus.req_valid) begin
                s_pend     = 1'b1;
                s_last_idx = sbus.req_index;
                s_acc++;
            end
        end
    end

    task automatic check_reset(input string pfx);
        check({pfx, "_busy"}, 32'(busy), 32'd0);
        check({pfx, "_done"}, 32'(done), 32'd0);
        check({pfx, "_req_valid"}, 32'(bus.req_valid), 32'd0);
        check({pfx, "_req_index"}, bus.req_index, 32'd0);
        check({pfx, "_best_sad"}, best_sad, 32'hFFFF_FFFF);
        check({pfx, "_best_index"}, best_index, 32'd0);
        check({pfx, "_best_x"}, best_x, 32'd0);
        check({pfx, "_best_y"}, best_y, 32'd0);
    endtask

    // One search: queue expectations, pulse start, wait for done (or abort after abort_at requests)
    task automatic run_search(input int m, input bit rr, input bit inj, input bit pulse,
                              input bit measure, input int abort_at);
        int   npos;
        int   cyc;
        bit   got;
        bit   stop;
        res_t r;
        mode       = m;
        rand_ready = rr;
        inject_en  = inj;
        acc_cnt    = 0;
        npos       = 0;
        stop       = 1'b0;
        for (int x = 0; x < P && !stop; x++) begin
            for (int y = 0; y < P && !stop; y++) begin
                exp_idx_q.push_back(32'(x * FRAME_W + y));
                npos++;
`ifdef SAD_EARLY_EXIT_EN
                if (sad_model(m, 32'(x * FRAME_W + y)) == 32'd0) stop = 1'b1;
`endif
            end
        end
        if (m == 1)      r = '{32'd5, 32'd0, 32'd0, 32'd0};
        else if (m == 2) r = '{32'd0, 32'd130, 32'd2, 32'd2};
        else             r = '{32'd0, 32'd1000, 32'd15, 32'd40};
        if (abort_at == 0) res_q.push_back(r);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        got   = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        while (cyc < 40000) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (abort_at > 0 && acc_cnt >= abort_at) break;
            @(negedge clk);
            cyc++;
            start = pulse && (cyc % 500 == 250);
        end
        start = 1'b0;

        if (abort_at > 0) begin
            if (cyc >= 40000) fail("abort_timeout", 32'(acc_cnt));
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            check_reset("abort");
            exp_idx_q.delete();
            rst_n = 1'b1;
            repeat (3) @(negedge clk);
            check("abort_no_done", 32'(res_q.size()), 32'd0);
            return;
        end

        if (!got) fail("done_timeout", 32'(cyc));
        if (measure) check("latency", 32'(cyc), 32'(3 * npos + 1));
        repeat (3) @(negedge clk);
        check("requests_left", 32'(exp_idx_q.size()), 32'd0);
        check("results_left", 32'(res_q.size()), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        rst_n   = 1'b0;
        start   = 1'b0;
        s_start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_search(0, 1'b0, 1'b0, 1'b0, 1'b1, 0);   // |index-1000|, always ready
        run_search(1, 1'b0, 1'b0, 1'b0, 1'b1, 0);   // constant SAD: tie keeps first
        run_search(0, 1'b1, 1'b0, 1'b0, 1'b0, 0);   // random ready
        run_search(0, 1'b0, 1'b0, 1'b0, 1'b0, 100); // reset at request 100
        run_search(0, 1'b0, 1'b0, 1'b0, 1'b1, 0);   // same result after abort
        run_search(0, 1'b1, 1'b1, 1'b1, 1'b0, 0);   // start while busy, stray results
`ifdef SAD_EARLY_EXIT_EN
        run_search(2, 1'b0, 1'b0, 1'b0, 1'b1, 0);   // zero SAD at 130 ends search
`endif

        // Single-position window: one request at index 0
        s_acc   = 0;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        cyc     = 1;
        while (!s_done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("p1_latency", 32'(cyc), 32'd4);
        check("p1_requests", 32'(s_acc), 32'd1);
        check("p1_index", s_last_idx, 32'd0);
        check("p1_best_sad", s_best_sad, 32'd7);
        check("p1_best_index", s_best_index, 32'd0);
        check("p1_best_x", s_best_x, 32'd0);
        check("p1_best_y", s_best_y, 32'd0);
        repeat (3) @(negedge clk);
        check("p1_requests_after", 32'(s_acc), 32'd1);
        check("p1_done_pulse", 32'(s_done), 32'd0);
        check("p1_busy_after", 32'(s_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
